// File: rtl/washer_seq.sv
// Washing-machine program sequencer: fill/wash/drain cycles, optional dry,
// pause/resume, latched emergency alarm and a two-digit BCD countdown.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   tick                     one-clk pulse per second; all timing advances on it
//   start, pause             one-clk pulses (start accepted in IDLE only)
//   emergency                level-sensitive stop, latched into ALARM
//   mode, cycles             program select and wash-cycle count (sampled at start)
//   inlet..fan               registered actuator enables
//   alarm, busy, done        status; done is a one-clk completion pulse
//   state, remain            current state code and seconds left in the program
//   bcd_hi, bcd_lo           tens/units of remain, saturated at 99
module washer_seq #(
    parameter int CNT_W   = 8,
    parameter int FILL_T  = 3,
    parameter int WASH_T  = 10,
    parameter int REV_T   = 2,
    parameter int DRAIN_T = 3,
    parameter int DRY_T   = 5,
    parameter int MAX_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             emergency,
    input  logic [1:0]       mode,
    input  logic [2:0]       cycles,
    output logic             inlet,
    output logic             drain,
    output logic             dry,
    output logic             zheng,
    output logic             fan,
    output logic             alarm,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] remain,
    output logic [3:0]       bcd_hi,
    output logic [3:0]       bcd_lo
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_DRAIN = 3'd3,
        S_DRY   = 3'd4,
        S_PAUSE = 3'd5,
        S_ALARM = 3'd6
    } state_e;

    state_e           state_q, state_d;
    state_e           saved_q, saved_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] rev_q, rev_d;
    logic [2:0]       cyc_q, cyc_d;
    logic             dir_q, dir_d;    // 0: zheng, 1: fan
    logic             full_q, full_d;  // program ends with DRY
    logic             done_q, done_d;
    logic             inlet_q, drain_q, dry_q, zheng_q, fan_q;
    logic             alarm_q, busy_q;
    logic [2:0]       c_eff;
    logic [31:0]      rem_sat;

    always_comb begin
        if (cycles == 3'd0)
            c_eff = 3'd1;
        else if (32'(cycles) > MAX_CYC)
            c_eff = 3'(MAX_CYC);
        else
            c_eff = cycles;
    end

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        rev_d    = rev_q;
        cyc_d    = cyc_q;
        dir_d    = dir_q;
        full_d   = full_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cyc_d  = c_eff;
                    full_d = (mode != 2'd1);
                    if (mode == 2'd2) begin
                        state_d  = S_DRY;
                        phase_d  = CNT_W'(DRY_T);
                        remain_d = CNT_W'(DRY_T);
                    end else begin
                        state_d  = S_FILL;
                        phase_d  = CNT_W'(FILL_T);
                        remain_d = CNT_W'(32'(c_eff) * (FILL_T + WASH_T + DRAIN_T)
                                   + ((mode != 2'd1) ? DRY_T : 0));
                    end
                end
            end
            S_FILL, S_WASH, S_DRAIN, S_DRY: begin
                if (emergency) begin
                    state_d = S_ALARM;
                end else if (pause) begin
                    saved_d = state_q;
                    state_d = S_PAUSE;
                end else if (tick) begin
                    remain_d = remain_q - CNT_W'(1);
                    phase_d  = phase_q - CNT_W'(1);
                    // drum reverses every REV_T ticks while washing
                    if (state_q == S_WASH) begin
                        if (rev_q == CNT_W'(1)) begin
                            dir_d = ~dir_q;
                            rev_d = CNT_W'(REV_T);
                        end else begin
                            rev_d = rev_q - CNT_W'(1);
                        end
                    end
                    if (phase_q == CNT_W'(1)) begin
                        if (state_q == S_FILL) begin
                            state_d = S_WASH;
                            phase_d = CNT_W'(WASH_T);
                            dir_d   = 1'b0;
                            rev_d   = CNT_W'(REV_T);
                        end else if (state_q == S_WASH) begin
                            state_d = S_DRAIN;
                            phase_d = CNT_W'(DRAIN_T);
                        end else if (state_q == S_DRAIN && cyc_q > 3'd1) begin
                            cyc_d   = cyc_q - 3'd1;
                            state_d = S_FILL;
                            phase_d = CNT_W'(FILL_T);
                        end else if (state_q == S_DRAIN && full_q) begin
                            state_d = S_DRY;
                            phase_d = CNT_W'(DRY_T);
                        end else begin
                            state_d  = S_IDLE;
                            phase_d  = '0;
                            remain_d = '0;
                            done_d   = 1'b1;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (emergency)
                    state_d = S_ALARM;
                else if (pause)
                    state_d = saved_q;
            end
            S_ALARM: begin
                state_d = S_ALARM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            saved_q  <= S_IDLE;
            phase_q  <= '0;
            remain_q <= '0;
            rev_q    <= '0;
            cyc_q    <= '0;
            dir_q    <= 1'b0;
            full_q   <= 1'b0;
            done_q   <= 1'b0;
            inlet_q  <= 1'b0;
            drain_q  <= 1'b0;
            dry_q    <= 1'b0;
            zheng_q  <= 1'b0;
            fan_q    <= 1'b0;
            alarm_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            rev_q    <= rev_d;
            cyc_q    <= cyc_d;
            dir_q    <= dir_d;
            full_q   <= full_d;
            done_q   <= done_d;
            // actuators decoded from next state so they line up with state
            inlet_q  <= (state_d == S_FILL);
            drain_q  <= (state_d == S_DRAIN) || (state_d == S_ALARM);
            dry_q    <= (state_d == S_DRY);
            zheng_q  <= (state_d == S_WASH) && !dir_d;
            fan_q    <= (state_d == S_WASH) && dir_d;
            alarm_q  <= (state_d == S_ALARM);
            busy_q   <= (state_d != S_IDLE) && (state_d != S_ALARM);
        end
    end

    always_comb begin
        rem_sat = 32'(remain_q);
        if (rem_sat > 32'd99)
            rem_sat = 32'd99;
        bcd_hi = 4'(rem_sat / 32'd10);
        bcd_lo = 4'(rem_sat % 32'd10);
    end

    assign inlet  = inlet_q;
    assign drain  = drain_q;
    assign dry    = dry_q;
    assign zheng  = zheng_q;
    assign fan    = fan_q;
    assign alarm  = alarm_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign state  = state_q;
    assign remain = remain_q;

endmodule

// File: tb/tb_washer_seq.sv
// Self-checking bench for washer_seq: directed scenarios then random traffic,
// compared against a per-second timeline model of the programme.
module tb_washer_seq;

    logic       clk = 1'b0;
    logic       rst, tick, start, pause, emergency;
    logic [1:0] mode;
    logic [2:0] cycles;
    logic       inlet, drain, dry, zheng, fan, alarm, busy, done;
    logic [2:0] state;
    logic [7:0] remain;
    logic [3:0] bcd_hi, bcd_lo;

    washer_seq dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
        .emergency(emergency), .mode(mode), .cycles(cycles),
        .inlet(inlet), .drain(drain), .dry(dry), .zheng(zheng), .fan(fan),
        .alarm(alarm), .busy(busy), .done(done), .state(state),
        .remain(remain), .bcd_hi(bcd_hi), .bcd_lo(bcd_lo)
    );

    always #5 clk = ~clk;

    // one entry per remaining second: phase code and drum direction
    typedef struct {
        int st;
        bit zh;
        bit fn;
    } ent_t;

    ent_t tl[$];
    bit   m_pause, m_alarm, m_done;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void build(input int md, input int cy);
        int c;
        ent_t e;
        c = (cy == 0) ? 1 : ((cy > 3) ? 3 : cy);
        tl.delete();
        if (md != 2) begin
            for (int k = 0; k < c; k++) begin
                for (int i = 0; i < 3; i++) begin
                    e = '{1, 1'b0, 1'b0}; tl.push_back(e);
                end
                for (int i = 0; i < 10; i++) begin
                    e.st = 2;
                    e.zh = ((i / 2) % 2 == 0);
                    e.fn = !e.zh;
                    tl.push_back(e);
                end
                for (int i = 0; i < 3; i++) begin
                    e = '{3, 1'b0, 1'b0}; tl.push_back(e);
                end
            end
        end
        if (md != 1) begin
            for (int i = 0; i < 5; i++) begin
                e = '{4, 1'b0, 1'b0}; tl.push_back(e);
            end
        end
    endfunction

    task automatic step(input bit t, input bit s, input bit p,
                        input bit e, input bit r);
        bit   run, act;
        int   est, rem, rs;
        ent_t f;
        tick = t; start = s; pause = p; emergency = e; rst = r;
        @(posedge clk);
        m_done = 1'b0;
        if (r) begin
            tl.delete(); m_pause = 1'b0; m_alarm = 1'b0;
        end else if (m_alarm) begin
            m_alarm = 1'b1;
        end else if (tl.size() != 0) begin
            if (e) m_alarm = 1'b1;
            else if (m_pause) begin
                if (p) m_pause = 1'b0;
            end else if (p) m_pause = 1'b1;
            else if (t) begin
                void'(tl.pop_front());
                if (tl.size() == 0) m_done = 1'b1;
            end
        end else if (s) begin
            build(int'(mode), int'(cycles));
        end
        #1;
        run = (tl.size() != 0);
        act = run && !m_pause && !m_alarm;
        f = '{0, 1'b0, 1'b0};
        if (run) f = tl[0];
        est = m_alarm ? 6 : (m_pause ? 5 : (run ? f.st : 0));
        rem = tl.size();
        rs = (rem > 99) ? 99 : rem;
        chk("state", 32'(state), est);
        chk("remain", 32'(remain), rem);
        chk("bcd_hi", 32'(bcd_hi), rs / 10);
        chk("bcd_lo", 32'(bcd_lo), rs % 10);
        chk("inlet", 32'(inlet), 32'(act && f.st == 1));
        chk("drain", 32'(drain), 32'(m_alarm || (act && f.st == 3)));
        chk("dry", 32'(dry), 32'(act && f.st == 4));
        chk("zheng", 32'(zheng), 32'(act && f.st == 2 && f.zh));
        chk("fan", 32'(fan), 32'(act && f.st == 2 && f.fn));
        chk("alarm", 32'(alarm), 32'(m_alarm));
        chk("busy", 32'(busy), 32'(run && !m_alarm));
        chk("done", 32'(done), 32'(m_done));
        chk("excl_zf", 32'(zheng && fan), 0);
    endtask

    task automatic tk();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    bit seen_dry;
    bit z_seen[10];
    bit zpat[10];

    initial begin
        zpat = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
        m_pause = 0; m_alarm = 0; m_done = 0;
        mode = 2'd0; cycles = 3'd1;
        step(0, 0, 0, 0, 1);
        chk("rst_state", 32'(state), 0);
        chk("rst_remain", 32'(remain), 0);

        // full program, one cycle
        step(0, 1, 0, 0, 0);
        chk("full_remain", 32'(remain), 21);
        chk("full_bcd_hi", 32'(bcd_hi), 2);
        chk("full_bcd_lo", 32'(bcd_lo), 1);
        repeat (20) tk();
        step(1, 0, 0, 0, 0);
        chk("full_done", 32'(done), 1);
        chk("full_idle", 32'(state), 0);
        step(0, 0, 0, 0, 0);
        chk("done_once", 32'(done), 0);

        // wash only, cycles clamp
        mode = 2'd1; cycles = 3'd5;
        step(0, 1, 0, 0, 0);
        chk("wash_remain", 32'(remain), 48);
        chk("wash_bcd_hi", 32'(bcd_hi), 4);
        chk("wash_bcd_lo", 32'(bcd_lo), 8);
        seen_dry = 0;
        for (int i = 0; i < 48; i++) begin
            if (state == 3'd4) seen_dry = 1;
            tk();
        end
        chk("wash_nodry", 32'(seen_dry), 0);
        chk("wash_idle", 32'(state), 0);

        // drum direction pattern
        mode = 2'd0; cycles = 3'd1;
        step(0, 1, 0, 0, 0);
        repeat (3) tk();
        for (int i = 0; i < 10; i++) begin
            z_seen[i] = zheng;
            chk("dir_fan", 32'(fan), 32'(!zpat[i]));
            tk();
        end
        for (int i = 0; i < 10; i++)
            chk("dir_zheng", 32'(z_seen[i]), 32'(zpat[i]));
        repeat (8) tk();

        // pause and resume mid-wash
        step(0, 1, 0, 0, 0);
        repeat (6) tk();
        chk("pz_pre", 32'(remain), 15);
        step(0, 0, 1, 0, 0);
        chk("pz_state", 32'(state), 5);
        repeat (4) begin
            tk();
            chk("pz_hold", 32'(remain), 15);
        end
        step(0, 0, 1, 0, 0);
        chk("pz_resume", 32'(state), 2);
        chk("pz_remain", 32'(remain), 15);
        repeat (14) tk();
        step(1, 0, 0, 0, 0);
        chk("pz_done", 32'(done), 1);

        // emergency with tick during dry
        step(0, 1, 0, 0, 0);
        repeat (18) tk();
        chk("em_pre", 32'(state), 4);
        step(1, 0, 0, 1, 0);
        chk("em_state", 32'(state), 6);
        chk("em_alarm", 32'(alarm), 1);
        chk("em_drain", 32'(drain), 1);
        chk("em_dry", 32'(dry), 0);
        chk("em_remain", 32'(remain), 3);
        step(0, 1, 0, 0, 0);
        chk("em_start", 32'(state), 6);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("em_rst", 32'(state), 0);
        chk("em_rst_drain", 32'(drain), 0);

        // idle ignores emergency/pause; start while busy; cycles=0
        step(0, 0, 1, 1, 0);
        chk("idle_em", 32'(state), 0);
        cycles = 3'd0;
        step(0, 1, 0, 0, 0);
        chk("c0_remain", 32'(remain), 21);
        repeat (2) tk();
        mode = 2'd2;
        step(0, 1, 0, 0, 0);
        chk("busy_start", 32'(remain), 19);
        chk("busy_state", 32'(state), 1);
        step(0, 0, 0, 0, 1);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            bit t, s, p, e, r;
            mode = 2'($urandom_range(0, 3));
            cycles = 3'($urandom_range(0, 7));
            t = ($urandom_range(0, 1) == 0);
            s = ($urandom_range(0, 15) == 0);
            p = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 599) == 0);
            r = ($urandom_range(0, 999) == 0) ||
                (m_alarm && $urandom_range(0, 19) == 0);
            step(t, s, p, e, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
